// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate over a word-organised byte memory: zero or WAIT_STATES extra data-phase cycles,
// two-cycle ERROR response; stalls the bus only through HREADYOUT.
module ahb_slave_mem #(
   parameter int                           AHB_DATA_WIDTH    = 64,
   parameter int                           AHB_ADDRESS_WIDTH = 32,
   parameter int                           MEM_BYTES         = 4096,
   parameter int                           WAIT_STATES       = 0,
   parameter logic [AHB_ADDRESS_WIDTH-1:0] ERR_ADDR_LO       = 'hF00,
   parameter logic [AHB_ADDRESS_WIDTH-1:0] ERR_ADDR_HI       = 'hFFF
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         HSEL,
   input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [2:0]                   HBURST,
   input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
   input  logic                         HREADY,
   output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
   output logic                         HREADYOUT,
   output logic                         HRESP
);

   localparam int BUS_BYTES = AHB_DATA_WIDTH / 8;
   localparam int LANE_W    = $clog2(BUS_BYTES);
   localparam int WORDS     = MEM_BYTES / BUS_BYTES;
   localparam int MEM_AW    = $clog2(MEM_BYTES);
   localparam logic [2:0] MAX_SIZE = 3'(LANE_W);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                      state_q, state_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic                        dp_vld_q, dp_vld_d;
   logic                        dp_write_q, dp_write_d;
   logic [MEM_AW-1:0]           dp_addr_q, dp_addr_d;
   logic [2:0]                  dp_size_q, dp_size_d;
   logic [AHB_DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

   logic [AHB_DATA_WIDTH-1:0]   mem [WORDS];

   logic                        accept;
   logic                        req_err;
   logic                        commit;
   logic [7:0]                  size_mask;
   logic [BUS_BYTES-1:0]        wr_lanes;
   logic [AHB_DATA_WIDTH-1:0]   rd_word;
   int                          lane_lo;
   int                          lane_hi;
   logic                        unused_ok;

   assign unused_ok = ^{HBURST, HTRANS[0]};

   assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
   assign HRDATA    = hrdata_q;

   assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
   assign commit    = HREADYOUT & dp_vld_q & dp_write_q;
   assign size_mask = (8'd1 << HSIZE) - 8'd1;

   assign req_err = (HADDR >= AHB_ADDRESS_WIDTH'(MEM_BYTES))
                  || ((HADDR >= ERR_ADDR_LO) && (HADDR <= ERR_ADDR_HI))
                  || (HSIZE > MAX_SIZE)
                  || (|(HADDR[7:0] & size_mask));

   // Only legal sizes reach the data phase, so lane_hi never exceeds the bus width.
   always_comb begin
      lane_lo  = int'(dp_addr_q[LANE_W-1:0]);
      lane_hi  = lane_lo + (1 << dp_size_q) - 1;
      wr_lanes = '0;
      for (int b = 0; b < BUS_BYTES; b++) begin
         wr_lanes[b] = (b >= lane_lo) && (b <= lane_hi);
      end
   end

   // A read accepted on the edge a write to the same word commits sees the new lanes.
   always_comb begin
      rd_word = mem[HADDR[MEM_AW-1:LANE_W]];
      if (commit && (dp_addr_q[MEM_AW-1:LANE_W] == HADDR[MEM_AW-1:LANE_W])) begin
         for (int b = 0; b < BUS_BYTES; b++) begin
            if (wr_lanes[b]) begin
               rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dp_vld_d   = dp_vld_q;
      dp_write_d = dp_write_q;
      dp_addr_d  = dp_addr_q;
      dp_size_d  = dp_size_q;
      hrdata_d   = hrdata_q;
      if (HREADYOUT && dp_vld_q) begin
         dp_vld_d = 1'b0;
      end
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (accept) begin
               dp_write_d = HWRITE;
               dp_addr_d  = HADDR[MEM_AW-1:0];
               dp_size_d  = HSIZE;
               if (req_err) begin
                  state_d  = ST_ERR1;
                  hrdata_d = '0;
               end else begin
                  dp_vld_d = 1'b1;
                  if (!HWRITE) begin
                     hrdata_d = rd_word;
                  end
                  if (WAIT_STATES > 0) begin
                     state_d = ST_WAIT;
                     cnt_d   = 4'(WAIT_STATES);
                  end
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         dp_vld_q   <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= '0;
         dp_size_q  <= '0;
         hrdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dp_vld_q   <= dp_vld_d;
         dp_write_q <= dp_write_d;
         dp_addr_q  <= dp_addr_d;
         dp_size_q  <= dp_size_d;
         hrdata_q   <= hrdata_d;
      end
   end

   // Reset clears dp_vld_q, so an in-flight write never commits.
   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int b = 0; b < BUS_BYTES; b++) begin
            if (wr_lanes[b]) begin
               mem[dp_addr_q[MEM_AW-1:LANE_W]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance behind one pipelined AHB master,
// expected responses queued as beats are placed on the bus and checked when each data phase ends.
module tb_ahb_slave_mem;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [63:0] hwdata;
   logic        hsel_req;
   int          cur;

   logic        hsel0, hsel2;
   logic [63:0] hrdata0, hrdata2, hrdata;
   logic        hro0, hro2, hro;
   logic        hresp0, hresp2, hresp;

   assign hsel0  = hsel_req && (cur == 0);
   assign hsel2  = hsel_req && (cur == 1);
   assign hrdata = (cur == 1) ? hrdata2 : hrdata0;
   assign hro    = (cur == 1) ? hro2 : hro0;
   assign hresp  = (cur == 1) ? hresp2 : hresp0;

   ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro0),
      .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));

   ahb_slave_mem #(.WAIT_STATES(2)) u_dut2 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro2),
      .HRDATA(hrdata2), .HREADYOUT(hro2), .HRESP(hresp2));

   typedef struct packed {
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [63:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic        nop;
      logic        isrd;
      logic        err;
      logic [63:0] rdata;
      logic [31:0] waits;
   } exp_t;

   xfer_t       stim_q[$];
   exp_t        sb_q[$];
   logic [7:0]  model [2][4096];
   int          vectors = 0;
   int          miscompares = 0;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   function automatic logic exp_err(logic [31:0] a, logic [2:0] s);
      logic [31:0] m;
      m = (32'd1 << s) - 32'd1;
      return (a >= 32'd4096) || ((a >= 32'hF00) && (a <= 32'hFFF)) || (s > 3'd3) || ((a & m) != 32'd0);
   endfunction

   function automatic logic [63:0] model_word(logic [31:0] a);
      logic [63:0] w;
      int base;
      base = int'(a & ~32'd7);
      for (int i = 0; i < 8; i++) w[8*i +: 8] = model[cur][base + i];
      return w;
   endfunction

   task automatic push_x(logic [1:0] t, logic w, logic [31:0] a, logic [2:0] s, logic [63:0] d);
      xfer_t x;
      x.trans = t; x.wr = w; x.addr = a; x.size = s; x.wdata = d;
      stim_q.push_back(x);
   endtask

   task automatic drive_idle();
      htrans = T_IDLE; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
   endtask

   // Put a beat in the address phase and record what its data phase must return.
   task automatic place(xfer_t x);
      exp_t e;
      int lane;
      haddr = x.addr; htrans = x.trans; hwrite = x.wr; hsize = x.size; hburst = 3'b001;
      e.nop   = !x.trans[1];
      e.err   = !e.nop && exp_err(x.addr, x.size);
      e.isrd  = !x.wr;
      e.waits = e.nop ? 32'd0 : (e.err ? 32'd1 : ((cur == 1) ? 32'd2 : 32'd0));
      e.rdata = 64'd0;
      if (!e.nop && !e.err) begin
         if (!x.wr) begin
            e.rdata = model_word(x.addr);
         end else begin
            for (int i = 0; i < (1 << x.size); i++) begin
               lane = int'(x.addr[2:0]) + i;
               model[cur][int'(x.addr) + i] = x.wdata[8*lane +: 8];
            end
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic run_bus(string name);
      xfer_t ap;
      exp_t  e;
      bit    ap_v, dp_v, adv, respbad, done;
      int    lows, cyc;
      ap_v = 0; dp_v = 0; lows = 0; respbad = 0; done = 0; cyc = 0;
      @(posedge clk); #1;
      hsel_req = 1'b1;
      if (stim_q.size() > 0) begin
         ap = stim_q.pop_front(); ap_v = 1; place(ap);
      end else begin
         drive_idle();
      end
      while (cyc < 400) begin
         cyc++;
         @(negedge clk);
         if (dp_v) begin
            if (hro !== 1'b1) begin
               lows++;
               if (hresp !== sb_q[0].err) respbad = 1;
            end else begin
               e = sb_q.pop_front();
               dp_v = 0;
               vectors++;
               if (hresp !== e.err) begin
                  miscompares++;
                  $display("FAIL %s resp: got %0b want %0b", name, hresp, e.err);
               end
               vectors++;
               if ((lows != int'(e.waits)) || respbad) begin
                  miscompares++;
                  $display("FAIL %s waits: got %0d low cycles (resp glitch %0b) want %0d", name, lows, respbad, e.waits);
               end
               if (e.err || (e.isrd && !e.nop)) begin
                  vectors++;
                  if (hrdata !== e.rdata) begin
                     miscompares++;
                     $display("FAIL %s rdata: got %h want %h", name, hrdata, e.rdata);
                  end
               end
            end
         end
         adv = (hro === 1'b1);
         if (!ap_v && !dp_v && (stim_q.size() == 0)) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
         if (adv) begin
            dp_v = ap_v; lows = 0; respbad = 0;
            if (ap_v) hwdata = ap.wdata;
            if (stim_q.size() > 0) begin
               ap = stim_q.pop_front(); ap_v = 1; place(ap);
            end else begin
               ap_v = 0; drive_idle();
            end
         end
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL %s timeout: got no completion in %0d cycles want all beats done", name, cyc);
         stim_q.delete(); sb_q.delete(); drive_idle();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hsel_req = 1'b0; hwdata = 64'd0; drive_idle();
      #12;
      vectors += 6;
      if (hro0 !== 1'b1)     begin miscompares++; $display("FAIL reset hreadyout0: got %b want 1", hro0); end
      if (hresp0 !== 1'b0)   begin miscompares++; $display("FAIL reset hresp0: got %b want 0", hresp0); end
      if (hrdata0 !== 64'd0) begin miscompares++; $display("FAIL reset hrdata0: got %h want 0", hrdata0); end
      if (hro2 !== 1'b1)     begin miscompares++; $display("FAIL reset hreadyout2: got %b want 1", hro2); end
      if (hresp2 !== 1'b0)   begin miscompares++; $display("FAIL reset hresp2: got %b want 0", hresp2); end
      if (hrdata2 !== 64'd0) begin miscompares++; $display("FAIL reset hrdata2: got %h want 0", hrdata2); end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_dword();
      cur = 0;
      push_x(T_NSEQ, 1, 32'h10, 3'd3, 64'h1122334455667788);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h18, 3'd3, 64'hA5A5_0F0F_C3C3_9669);
      push_x(T_NSEQ, 0, 32'h18, 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      run_bus("dword");
   endtask

   task automatic test_byte_fwd();
      cur = 0;
      push_x(T_NSEQ, 1, 32'h13, 3'd0, 64'hDEADBEEF_ABCAFE55);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h16, 3'd1, 64'h5AA5FFFF_FFFFFFFF);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h1C, 3'd2, 64'h0BADF00D_11111111);
      push_x(T_NSEQ, 0, 32'h18, 3'd3, 64'd0);
      run_bus("byte_fwd");
   endtask

   task automatic test_errors();
      cur = 0;
      push_x(T_NSEQ, 1, 32'hF08, 3'd3, 64'h0123456789ABCDEF);
      push_x(T_NSEQ, 0, 32'hF08, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h12, 3'd2, 64'hFFFFFFFF_FFFFFFFF);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h1000, 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h20, 3'd4, 64'd0);
      push_x(T_NSEQ, 0, 32'h02, 3'd2, 64'd0);
      push_x(T_NSEQ, 0, 32'h18, 3'd3, 64'd0);
      run_bus("errors");
   endtask

   task automatic test_busy_burst();
      logic [31:0] d;
      cur = 0;
      for (int k = 0; k < 8; k++) begin
         d = 32'hC0DE0000 + 32'(k);
         if (k == 3) push_x(T_BUSY, 1, 32'h10, 3'd3, 64'hBAD0BAD0_BAD0BAD0);
         push_x((k == 0) ? T_NSEQ : T_SEQ, 1, 32'h100 + 32'(4*k), 3'd2, {d, d});
      end
      for (int k = 0; k < 4; k++) push_x(T_NSEQ, 0, 32'h100 + 32'(8*k), 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h10, 3'd3, 64'd0);
      push_x(T_IDLE, 0, 32'h0, 3'd0, 64'd0);
      push_x(T_NSEQ, 0, 32'h18, 3'd3, 64'd0);
      run_bus("busy_burst");
   endtask

   task automatic test_wait_burst();
      cur = 1;
      push_x(T_NSEQ, 1, 32'h20, 3'd3, 64'h2222_2222_1111_1111);
      push_x(T_NSEQ, 1, 32'h28, 3'd3, 64'h4444_4444_3333_3333);
      push_x(T_NSEQ, 0, 32'h20, 3'd2, 64'd0);
      push_x(T_SEQ,  0, 32'h24, 3'd2, 64'd0);
      push_x(T_SEQ,  0, 32'h28, 3'd2, 64'd0);
      push_x(T_SEQ,  0, 32'h2C, 3'd2, 64'd0);
      push_x(T_NSEQ, 1, 32'hFF0, 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h28, 3'd3, 64'd0);
      run_bus("wait_burst");
   endtask

   task automatic test_back_to_back();
      cur = 1;
      push_x(T_NSEQ, 1, 32'h30, 3'd3, 64'h0F1E2D3C4B5A6978);
      push_x(T_NSEQ, 0, 32'h30, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h31, 3'd0, 64'h00000000_0000EE00);
      push_x(T_NSEQ, 0, 32'h30, 3'd3, 64'd0);
      push_x(T_NSEQ, 1, 32'h38, 3'd3, 64'h7777_6666_5555_4444);
      push_x(T_NSEQ, 1, 32'h3C, 3'd2, 64'h99887766_00000000);
      push_x(T_NSEQ, 0, 32'h38, 3'd3, 64'd0);
      push_x(T_NSEQ, 0, 32'h30, 3'd3, 64'd0);
      run_bus("back_to_back");
   endtask

   task automatic test_reset_mid();
      cur = 1;
      push_x(T_NSEQ, 1, 32'h40, 3'd3, 64'h1357_9BDF_2468_ACE0);
      push_x(T_NSEQ, 0, 32'h40, 3'd3, 64'd0);
      run_bus("reset_setup");
      @(posedge clk); #1;
      hsel_req = 1'b1; haddr = 32'h40; htrans = T_NSEQ; hwrite = 1'b1; hsize = 3'd3; hburst = 3'd0;
      @(posedge clk); #1;
      drive_idle(); hwdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      vectors++;
      if (hro2 !== 1'b0) begin miscompares++; $display("FAIL reset_mid wait: got hreadyout %b want 0", hro2); end
      #2 rst_n = 1'b0;
      #1;
      vectors += 3;
      if (hro2 !== 1'b1)     begin miscompares++; $display("FAIL reset_mid hreadyout: got %b want 1", hro2); end
      if (hresp2 !== 1'b0)   begin miscompares++; $display("FAIL reset_mid hresp: got %b want 0", hresp2); end
      if (hrdata2 !== 64'd0) begin miscompares++; $display("FAIL reset_mid hrdata: got %h want 0", hrdata2); end
      @(posedge clk); #1 rst_n = 1'b1;
      push_x(T_NSEQ, 0, 32'h40, 3'd3, 64'd0);
      run_bus("reset_readback");
   endtask

   initial begin
      cur = 0;
      test_reset();
      test_dword();
      test_byte_fwd();
      test_errors();
      test_busy_burst();
      test_wait_burst();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
